v_lane_seq: RTL and testbench
=============================

Name: v_lane_seq

Overview:
- Parametrised lane-group sequencer for the vector coprocessor; next generation of the fixed 4-group ALU/MUL lane wrapper.
- Latches one vector operation covering a register group of up to MAX_REGS registers of VLEN bits each.
- Splits the group into passes across 1..NUM_GROUPS lane groups, issues each pass to the external lane units, and collects their results.
- Drives per-group clock-enable (clock-gating) outputs so unused groups stay idle; start/ready and done handshakes replace free-running step counters.

Parameters:
- VLEN, 128, bits per vector register and per lane-group datapath.
- NUM_GROUPS, 4, physical lane groups instantiated; legal values 1, 2, 4.
- MAX_REGS, 4, maximum registers per operation (LMUL=4).

Ports:
- clk  in  1  clock.
- nrst  in  1  asynchronous active-low reset.
- start  in  1  request; accepted when start & ready.
- ready  out  1  high only in IDLE.
- lmul  in  3  0→1 reg, 1→2 regs, 2→4 regs; 3..7 reserved.
- lanes  in  2  requested groups: 0→1, 1→2, 2→4; 3 reserved.
- flush  in  1  abort the current operation.
- op_a  in  MAX_REGS*VLEN  operand A, register r at [r*VLEN +: VLEN].
- op_b  in  MAX_REGS*VLEN  operand B, same packing.
- lane_issue  out  1  one-cycle pulse presenting a pass to the lanes.
- lane_en  out  NUM_GROUPS  group g active in the current pass.
- lane_clk_en  out  NUM_GROUPS  clock enable for lane group g.
- lane_op_a  out  NUM_GROUPS*VLEN  per-group operand A.
- lane_op_b  out  NUM_GROUPS*VLEN  per-group operand B.
- lane_res  in  NUM_GROUPS*VLEN  per-group result.
- lane_res_valid  in  1  lane results valid this cycle.
- result  out  MAX_REGS*VLEN  collected results.
- done  out  1  one-cycle completion pulse.
- err  out  1  reserved config; valid with done.

Behaviour:
- Reset (async, nrst=0): state IDLE; ready=1; done=0; err=0; lane_issue=0; lane_en=0; lane_clk_en=0; lane_op_a/b=0; result=0.
- Accept (start & ready at an edge): latch op_a, op_b, lmul, lanes.
  - R = 1/2/4 from lmul.
  - G = min(2^lanes, NUM_GROUPS); lanes clamp to NUM_GROUPS.
  - P = ceil(R/G); pass index p=0.
  - Clear result to 0.
- Reserved config (lmul>2 or lanes=3): go to DONE directly, err=1 with done; no lane activity; result stays 0.
- start outside IDLE is ignored, with no queueing.
- FSM IDLE→ISSUE→WAIT→(ISSUE | DONE)→IDLE.
  - ISSUE (1 cycle): lane_issue=1. For group g: r = p*G + g; lane_en[g] = (g<G) && (r<R). Enabled groups get latched op_a/op_b register r; disabled groups are driven 0. Next state WAIT. lane_res_valid is ignored in ISSUE.
  - WAIT: lane_en and operands are held. On lane_res_valid, result register r takes lane_res group g for every enabled g. Then p increments: ISSUE if p+1<P, else DONE.
  - DONE (1 cycle): done=1, err as decided; next IDLE.
- lane_clk_en = lane_en in ISSUE/WAIT, else 0.
- result holds its value from DONE until the next accept.
- Latency: with lane latency L (lane_res_valid in the cycle ISSUE+L, L≥1), accept at cycle 0 gives done at cycle 1+P*(L+1).
- flush in ISSUE/WAIT: next state IDLE; no done; result cleared to 0; lane outputs go 0. flush in IDLE/DONE has no effect; a DONE pulse still completes. flush has priority over lane_res_valid in the same cycle.
- nrst low mid-operation returns all outputs to reset values immediately.
- Unused result registers (index ≥ R) read 0.

Test Plan:
- Reset: nrst=0 mid-WAIT → outputs immediately at reset values, ready=1. Release, start → normal operation.
- Config lanes=2, lmul=2, L=2, lane model result = op_a+op_b per 32-bit element, op_a reg r = {4{32'h10+r}}, op_b = {4{32'h1}}:
  - single pass, lane_en=4'b1111, done at cycle 4;
  - result reg r = {4{32'h11+r}}.
- Config lanes=0, lmul=2, L=2: 4 passes, lane_en=4'b0001 each pass, lane_op_a carries regs 0,1,2,3 in order, done at cycle 13, lane_clk_en[3:1] always 0.
- Config lanes=1, lmul=2, L=1: 2 passes (regs 0,1 then 2,3), done at cycle 5.
- Config lanes=2, lmul=0: lane_en=4'b0001, result regs 1..3 = 0, done at cycle 1+(L+1).
- Errors and abort:
  - lmul=3 → done and err at cycle 1, lane_issue never asserted;
  - flush during pass 1 of the lanes=0, lmul=2 case → no done, ready=1 next cycle, result=0;
  - start while busy is ignored.

Source files
------------

// File: rtl/v_lane_seq.sv
`default_nettype none
// ============================================================================
// Module      : v_lane_seq
// Description : Lane-group sequencer. Splits a vector op over 1..NUM_GROUPS
//               lane groups in passes, gates idle groups, collects results.
// Revision    : 1.0 - initial release
// ============================================================================
module v_lane_seq #(
    parameter int VLEN       = 128,
    parameter int NUM_GROUPS = 4,
    parameter int MAX_REGS   = 4
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       start,
    output logic                       ready,
    input  logic [2:0]                 lmul,
    input  logic [1:0]                 lanes,
    input  logic                       flush,
    input  logic [MAX_REGS*VLEN-1:0]   op_a,
    input  logic [MAX_REGS*VLEN-1:0]   op_b,
    output logic                       lane_issue,
    output logic [NUM_GROUPS-1:0]      lane_en,
    output logic [NUM_GROUPS-1:0]      lane_clk_en,
    output logic [NUM_GROUPS*VLEN-1:0] lane_op_a,
    output logic [NUM_GROUPS*VLEN-1:0] lane_op_b,
    input  logic [NUM_GROUPS*VLEN-1:0] lane_res,
    input  logic                       lane_res_valid,
    output logic [MAX_REGS*VLEN-1:0]   result,
    output logic                       done,
    output logic                       err
);
    localparam logic [1:0] c_LG  = (NUM_GROUPS >= 4) ? 2'd2 : ((NUM_GROUPS >= 2) ? 2'd1 : 2'd0);
    localparam int         c_RIW = (MAX_REGS > 1) ? $clog2(MAX_REGS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [MAX_REGS*VLEN-1:0] r_op_a;
    logic [MAX_REGS*VLEN-1:0] r_op_b;
    logic [VLEN-1:0]          r_res   [MAX_REGS];
    logic [VLEN-1:0]          w_a_reg [MAX_REGS];
    logic [VLEN-1:0]          w_b_reg [MAX_REGS];
    logic [c_RIW-1:0]         w_idx   [NUM_GROUPS];
    logic [2:0]               r_regs;
    logic [2:0]               r_grps;
    logic [2:0]               r_npass;
    logic [2:0]               r_pass;
    logic                     r_err;
    logic                     w_active;
    logic                     w_accept;
    logic                     w_rsv;
    logic                     w_collect;
    logic                     w_last;
    logic [1:0]               w_lr;
    logic [1:0]               w_lg;
    logic [1:0]               w_pl;
    logic [NUM_GROUPS-1:0]    w_en;

    // Config decode in log2 form: regs, groups (clamped), passes are powers of two
    assign w_rsv    = (lmul > 3'd2) || (lanes == 2'd3);
    assign w_lr     = lmul[1:0];
    assign w_lg     = (lanes > c_LG) ? c_LG : lanes;
    assign w_pl     = (w_lr > w_lg) ? (w_lr - w_lg) : 2'd0;

    assign w_active  = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign w_accept  = start && (r_state == S_IDLE);
    assign w_collect = (r_state == S_WAIT) && lane_res_valid && !flush;
    assign w_last    = (r_pass + 3'd1) >= r_npass;

    for (genvar r = 0; r < MAX_REGS; r++) begin : g_regs
        assign w_a_reg[r]              = r_op_a[r*VLEN +: VLEN];
        assign w_b_reg[r]              = r_op_b[r*VLEN +: VLEN];
        assign result[r*VLEN +: VLEN]  = r_res[r];
    end

    // Group g serves register p*G+g of the current pass
    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_lane
        logic [4:0] w_r;
        assign w_r     = 5'(r_pass) * 5'(r_grps) + 5'(g);
        assign w_idx[g] = w_r[c_RIW-1:0];
        assign w_en[g] = w_active && (5'(g) < 5'(r_grps)) && (w_r < 5'(r_regs))
                         && (w_r < 5'(MAX_REGS));
        assign lane_op_a[g*VLEN +: VLEN] = w_en[g] ? w_a_reg[w_idx[g]] : '0;
        assign lane_op_b[g*VLEN +: VLEN] = w_en[g] ? w_b_reg[w_idx[g]] : '0;
    end

    assign lane_en     = w_en;
    assign lane_clk_en = w_en;

    always_comb begin
        w_next     = r_state;
        ready      = 1'b0;
        lane_issue = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) w_next = w_rsv ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                lane_issue = 1'b1;
                w_next     = flush ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (flush)               w_next = S_IDLE;
                else if (lane_res_valid) w_next = w_last ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                done   = 1'b1;
                err    = r_err;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_regs  <= 3'd0;
            r_grps  <= 3'd0;
            r_npass <= 3'd0;
            r_pass  <= 3'd0;
            r_err   <= 1'b0;
            for (int r = 0; r < MAX_REGS; r++) r_res[r] <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op_a  <= op_a;
                r_op_b  <= op_b;
                r_regs  <= 3'd1 << w_lr;
                r_grps  <= 3'd1 << w_lg;
                r_npass <= 3'd1 << w_pl;
                r_pass  <= 3'd0;
                r_err   <= w_rsv;
                for (int r = 0; r < MAX_REGS; r++) r_res[r] <= '0;
            end else if (w_active && flush) begin
                for (int r = 0; r < MAX_REGS; r++) r_res[r] <= '0;
            end else if (w_collect) begin
                for (int g = 0; g < NUM_GROUPS; g++) begin
                    if (w_en[g]) r_res[w_idx[g]] <= lane_res[g*VLEN +: VLEN];
                end
                r_pass <= r_pass + 3'd1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_v_lane_seq.sv
`default_nettype none
// Testbench for v_lane_seq: table vectors, corner sequences and random
// operations checked against a behavioural lane/pass model.
module tb_v_lane_seq;
    localparam int VLEN = 128;
    localparam int NG   = 4;
    localparam int MR   = 4;
    localparam int W    = MR*VLEN;

    typedef struct {
        logic [2:0]  lm;
        logic [1:0]  ln;
        int          lat;
        int          exp_done;
        logic        exp_err;
        int          exp_passes;
        logic [3:0]  exp_en0;
        logic [31:0] exp_elem0;
    } vec_t;

    logic          clk = 1'b0;
    logic          nrst, start, flush, lane_res_valid;
    logic [2:0]    lmul;
    logic [1:0]    lanes;
    logic [W-1:0]  op_a, op_b, lane_res, result, lane_op_a, lane_op_b;
    logic          ready, lane_issue, done, err;
    logic [NG-1:0] lane_en, lane_clk_en;
    int            n_checks = 0;
    int            n_err    = 0;

    always #5 clk = ~clk;

    v_lane_seq #(.VLEN(VLEN), .NUM_GROUPS(NG), .MAX_REGS(MR)) dut (
        .clk(clk), .nrst(nrst), .start(start), .ready(ready), .lmul(lmul),
        .lanes(lanes), .flush(flush), .op_a(op_a), .op_b(op_b),
        .lane_issue(lane_issue), .lane_en(lane_en), .lane_clk_en(lane_clk_en),
        .lane_op_a(lane_op_a), .lane_op_b(lane_op_b), .lane_res(lane_res),
        .lane_res_valid(lane_res_valid), .result(result), .done(done), .err(err)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_wide();
        logic [W-1:0] v;
        for (int i = 0; i < W/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: 32-bit element-wise add of the first nregs registers, rest zero
    function automatic logic [W-1:0] elem_add(input logic [W-1:0] a, input logic [W-1:0] b, input int nregs);
        logic [W-1:0] s;
        s = '0;
        for (int i = 0; i < nregs*VLEN/32; i++) s[i*32 +: 32] = a[i*32 +: 32] + b[i*32 +: 32];
        return s;
    endfunction

    task automatic check_reset_outs();
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_issue", lane_issue, 0);
        check("rst_en", lane_en, 0);
        check("rst_clk_en", lane_clk_en, 0);
        check("rst_op_a", lane_op_a, 0);
        check("rst_op_b", lane_op_b, 0);
        check("rst_result", result, 0);
    endtask

    // Drives one operation, acts as the lane units (latency lat) and checks each pass.
    task automatic run_op(input logic [2:0] lm, input logic [1:0] ln, input int lat,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input int flush_at, input int rst_at, input bit busy_start,
                          output int done_cyc, output int passes,
                          output logic [NG-1:0] first_en, output logic got_err);
        int nr, ng, pend, bad_clk, bad_rdy, bad_hold;
        bit rsv, in_pass;
        logic [NG-1:0] cur_en;
        logic [W-1:0] exp_res, exp_oa, exp_ob, resp;
        rsv      = (lm > 3'd2) || (ln == 2'd3);
        nr       = rsv ? 0 : (1 << lm);
        ng       = (ln == 2'd3) ? 1 : (((1 << ln) < NG) ? (1 << ln) : NG);
        exp_res  = elem_add(a, b, nr);
        done_cyc = -1; passes = 0; first_en = '0; got_err = 1'b0;
        pend = -1; bad_clk = 0; bad_rdy = 0; bad_hold = 0; in_pass = 0; cur_en = '0; resp = '0;
        start = 1'b1; lmul = lm; lanes = ln; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0; op_a = rnd_wide(); op_b = rnd_wide();
        for (int c = 1; c <= 200; c++) begin
            if (lane_clk_en !== lane_en) bad_clk++;
            if (ready !== 1'b0) bad_rdy++;
            if (done === 1'b1) begin
                done_cyc = c;
                got_err  = err;
                check("result", result, exp_res);
                check("done_en", lane_en, 0);
                break;
            end
            if (lane_issue === 1'b1) begin
                cur_en = '0; exp_oa = '0; exp_ob = '0;
                for (int g = 0; g < NG; g++) begin
                    int r;
                    r = passes*ng + g;
                    if (g < ng && r < nr) begin
                        cur_en[g] = 1'b1;
                        exp_oa[g*VLEN +: VLEN] = a[r*VLEN +: VLEN];
                        exp_ob[g*VLEN +: VLEN] = b[r*VLEN +: VLEN];
                    end
                end
                check("lane_en", lane_en, cur_en);
                check("lane_op_a", lane_op_a, exp_oa);
                check("lane_op_b", lane_op_b, exp_ob);
                if (passes == 0) first_en = lane_en;
                resp = rnd_wide();
                for (int g = 0; g < NG; g++) begin
                    if (cur_en[g]) begin
                        for (int e = 0; e < VLEN/32; e++)
                            resp[g*VLEN+e*32 +: 32] = lane_op_a[g*VLEN+e*32 +: 32] + lane_op_b[g*VLEN+e*32 +: 32];
                    end
                end
                pend = c + lat; passes++; in_pass = 1;
            end else if (in_pass && lane_en !== cur_en) begin
                bad_hold++;
            end
            lane_res_valid = 1'b0; lane_res = rnd_wide();
            if (c == pend) begin
                lane_res_valid = 1'b1; lane_res = resp;
            end else if (lane_issue === 1'b1 && $urandom_range(0, 1) == 1) begin
                lane_res_valid = 1'b1;
            end
            flush = (c == flush_at);
            start = busy_start && (c == 2);
            if (start) begin lmul = 3'd0; lanes = 2'd2; end
            if (c == rst_at) begin
                nrst = 1'b0; #1;
                check_reset_outs();
                @(posedge clk); #1;
                nrst = 1'b1; start = 1'b0; flush = 1'b0; lane_res_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (c == flush_at) begin
                flush = 1'b0; lane_res_valid = 1'b0; start = 1'b0;
                check("flush_ready", ready, 1);
                check("flush_result", result, 0);
                check("flush_en", lane_en, 0);
                bad_rdy = 0;
                for (int k = 0; k < 3; k++) begin
                    if (done !== 1'b0 || ready !== 1'b1) bad_rdy++;
                    @(posedge clk); #1;
                end
                check("flush_idle", bad_rdy, 0);
                return;
            end
        end
        lane_res_valid = 1'b0; start = 1'b0;
        check("clk_en_match", bad_clk, 0);
        check("busy_ready", bad_rdy, 0);
        check("en_hold", bad_hold, 0);
        flush = (done_cyc >= 0 && flush_at == done_cyc);
        @(posedge clk); #1;
        flush = 1'b0;
        check("done_pulse", done, 0);
        check("idle_ready", ready, 1);
        check("res_hold", result, exp_res);
    endtask

    initial begin
        vec_t tbl [10];
        int dc, np, lat, nr, ng, pp;
        logic [NG-1:0] fe;
        logic ge;
        logic [2:0] lm;
        logic [1:0] ln;
        logic [W-1:0] pa, pb;

        tbl[0] = '{3'd2, 2'd2, 2,  4, 1'b0, 1, 4'b1111, 32'h11};
        tbl[1] = '{3'd2, 2'd0, 2, 13, 1'b0, 4, 4'b0001, 32'h11};
        tbl[2] = '{3'd2, 2'd1, 1,  5, 1'b0, 2, 4'b0011, 32'h11};
        tbl[3] = '{3'd0, 2'd2, 2,  4, 1'b0, 1, 4'b0001, 32'h11};
        tbl[4] = '{3'd0, 2'd2, 3,  5, 1'b0, 1, 4'b0001, 32'h11};
        tbl[5] = '{3'd1, 2'd2, 1,  3, 1'b0, 1, 4'b0011, 32'h11};
        tbl[6] = '{3'd3, 2'd0, 1,  1, 1'b1, 0, 4'b0000, 32'h0};
        tbl[7] = '{3'd1, 2'd3, 2,  1, 1'b1, 0, 4'b0000, 32'h0};
        tbl[8] = '{3'd7, 2'd1, 1,  1, 1'b1, 0, 4'b0000, 32'h0};
        tbl[9] = '{3'd1, 2'd0, 3,  9, 1'b0, 2, 4'b0001, 32'h11};

        for (int r = 0; r < MR; r++) begin
            for (int e = 0; e < VLEN/32; e++) begin
                pa[r*VLEN+e*32 +: 32] = 32'h10 + r;
                pb[r*VLEN+e*32 +: 32] = 32'h1;
            end
        end

        nrst = 1'b0; start = 1'b0; flush = 1'b0; lane_res_valid = 1'b0;
        lmul = '0; lanes = '0; op_a = '0; op_b = '0; lane_res = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outs();
        nrst = 1'b1;
        @(posedge clk); #1;

        // Reset asserted in the WAIT of pass 1, after register 0 was collected
        run_op(3'd2, 2'd0, 2, pa, pb, 0, 5, 1'b0, dc, np, fe, ge);
        check("rst_passes_seen", np, 2);

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].lm, tbl[i].ln, tbl[i].lat, pa, pb, 0, 0, (i == 0), dc, np, fe, ge);
            check("tbl_done_cycle", dc, tbl[i].exp_done);
            check("tbl_err", ge, tbl[i].exp_err);
            check("tbl_passes", np, tbl[i].exp_passes);
            check("tbl_first_en", fe, tbl[i].exp_en0);
            check("tbl_res_elem0", result[31:0], tbl[i].exp_elem0);
        end

        // Flush in pass 1 coinciding with lane_res_valid, flush in ISSUE, flush in DONE
        run_op(3'd2, 2'd0, 2, pa, pb, 6, 0, 1'b0, dc, np, fe, ge);
        check("flush_no_done", dc, -1);
        run_op(3'd2, 2'd2, 1, pa, pb, 1, 0, 1'b0, dc, np, fe, ge);
        check("flush_issue_no_done", dc, -1);
        run_op(3'd1, 2'd1, 2, pa, pb, 4, 0, 1'b0, dc, np, fe, ge);
        check("flush_in_done_cycle", dc, 4);

        for (int i = 0; i < 40; i++) begin
            lm  = 3'($urandom_range(0, 4));
            if (lm == 3'd4) lm = 3'($urandom_range(3, 7));
            ln  = 2'($urandom_range(0, 3));
            lat = $urandom_range(1, 4);
            nr  = 1 << lm;
            ng  = ((1 << ln) < NG) ? (1 << ln) : NG;
            pp  = (lm > 3'd2 || ln == 2'd3) ? 0 : (nr + ng - 1) / ng;
            run_op(lm, ln, lat, rnd_wide(), rnd_wide(), 0, 0, bit'($urandom_range(0, 1)), dc, np, fe, ge);
            check("rnd_done_cycle", dc, (pp == 0) ? 1 : 1 + pp*(lat + 1));
            check("rnd_err", ge, (pp == 0));
            check("rnd_passes", np, pp);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
